// File: rtl/batch_sequencer_pkg.sv
// Shared types, default parameters and bank-index helpers for the batch sequencer.
package batch_sequencer_pkg;

  localparam int DEF_DEPTH = 32;
  localparam int DEF_N     = 3;
  localparam int DEF_M     = 1;
  localparam int DEF_LAT   = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FILL  = 2'd1,
    ST_RUN   = 2'd2,
    ST_DRAIN = 2'd3
  } seq_state_e;

  // (b - d) mod 3 for bank indices in 0..2 and offsets in 0..2.
  function automatic logic [1:0] bank_sub(input logic [1:0] b, input logic [1:0] d);
    logic [2:0] t;
    t = {1'b0, b} + 3'd3 - {1'b0, d};
    return (t >= 3'd3) ? 2'(t - 3'd3) : t[1:0];
  endfunction

endpackage

// File: rtl/batch_sequencer_bank.sv
// batch_bank: three DEPTH x N sample banks for one channel with registered
// lookahead and forward/backward compute reads.
module batch_bank
  import batch_sequencer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int N     = DEF_N
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     beat,
  input  logic [1:0]               wr_bank,
  input  logic [1:0]               lh_bank,
  input  logic [1:0]               co_bank,
  input  logic [$clog2(DEPTH)-1:0] fwd_addr,
  input  logic [$clog2(DEPTH)-1:0] rev_addr,
  input  logic [N-1:0]             wr_data,
  output logic [N-1:0]             s_lh,
  output logic [N-1:0]             s_cof,
  output logic [N-1:0]             s_cob
);

  logic [N-1:0] mem_r [3][DEPTH];

  // Sample store; contents are logically discarded by reset, never cleared.
  always_ff @(posedge clk) begin
    if (beat) begin
      mem_r[wr_bank][fwd_addr] <= wr_data;
    end
  end

  // Read banks never alias the write bank, so no bypass is needed.
  always_ff @(posedge clk) begin
    if (rst) begin
      s_lh  <= {N{1'b0}};
      s_cof <= {N{1'b0}};
      s_cob <= {N{1'b0}};
    end else if (beat) begin
      s_lh  <= mem_r[lh_bank][rev_addr];
      s_cof <= mem_r[co_bank][fwd_addr];
      s_cob <= mem_r[co_bank][rev_addr];
    end
  end

endmodule

// File: rtl/batch_sequencer.sv
// Batch sequencer top: triple-buffered per-channel sample banks replayed as
// lookahead, forward and backward streams. Optional drain via BATCH_FLUSH_EN.
module batch_sequencer
  import batch_sequencer_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int N     = DEF_N,
  parameter int M     = DEF_M,
  parameter int LAT   = DEF_LAT
) (
  input  logic                     clk,
  input  logic                     rst,
`ifdef BATCH_FLUSH_EN
  input  logic                     flush,
`endif
  input  logic                     in_valid,
  input  logic [M*N-1:0]           in_data,
  output logic [M*N-1:0]           s_lh,
  output logic [M*N-1:0]           s_cof,
  output logic [M*N-1:0]           s_cob,
  output logic [$clog2(DEPTH)-1:0] bat_count,
  output logic [$clog2(DEPTH)-1:0] bat_count_rev,
  output logic                     lh_clear,
  output logic                     cb_load,
  output logic                     wr_sel,
  output logic                     stream_valid,
  output logic                     out_valid
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

  seq_state_e     state_r;
  logic [1:0]     batch_idx_r;
  logic [1:0]     lh_bank_s;
  logic [1:0]     co_bank_s;
  logic [LAT-1:0] ov_pipe_r;
  logic           beat_s;
  logic           drain_s;
  logic           last_s;
  logic           run_s;
  logic [M*N-1:0] wr_data_s;
`ifdef BATCH_FLUSH_EN
  logic           drain_cnt_r;
  logic           idle_clr_r;
`endif

  // Beat qualification and bank selection derived from the write bank.
  always_comb begin
`ifdef BATCH_FLUSH_EN
    drain_s = (state_r == ST_DRAIN) || ((state_r == ST_RUN) && flush);
`else
    drain_s = 1'b0;
`endif
    beat_s    = drain_s || in_valid;
    wr_data_s = drain_s ? {(M*N){1'b0}} : in_data;
    last_s    = (bat_count == LAST);
    run_s     = (state_r == ST_RUN) || (state_r == ST_DRAIN);
    lh_bank_s = bank_sub(batch_idx_r, 2'd1);
    co_bank_s = bank_sub(batch_idx_r, 2'd2);
  end

  // Sequencer FSM, batch counters, beat-aligned flags and out_valid delay line.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r       <= ST_IDLE;
      bat_count     <= {AW{1'b0}};
      bat_count_rev <= LAST;
      batch_idx_r   <= 2'd0;
      wr_sel        <= 1'b0;
      lh_clear      <= 1'b0;
      cb_load       <= 1'b0;
      stream_valid  <= 1'b0;
      ov_pipe_r     <= {LAT{1'b0}};
`ifdef BATCH_FLUSH_EN
      drain_cnt_r   <= 1'b0;
      idle_clr_r    <= 1'b0;
`endif
    end else if (beat_s) begin
      bat_count     <= last_s ? {AW{1'b0}} : bat_count + AW'(1);
      bat_count_rev <= last_s ? LAST : bat_count_rev - AW'(1);
      // bank_sub by 2 is the mod-3 increment.
      batch_idx_r   <= last_s ? bank_sub(batch_idx_r, 2'd2) : batch_idx_r;
      wr_sel        <= wr_sel ^ last_s;
      lh_clear      <= (bat_count == {AW{1'b0}});
      cb_load       <= (bat_count == {AW{1'b0}}) && run_s;
      stream_valid  <= run_s;
      ov_pipe_r     <= LAT'({ov_pipe_r, stream_valid});
`ifdef BATCH_FLUSH_EN
      idle_clr_r    <= 1'b0;
`endif
      case (state_r)
        ST_IDLE: state_r <= ST_FILL;
        ST_FILL: begin
          if (last_s && (batch_idx_r == 2'd1)) begin
            state_r <= ST_RUN;
          end
        end
        ST_RUN: begin
`ifdef BATCH_FLUSH_EN
          if (flush) begin
            state_r     <= ST_DRAIN;
            drain_cnt_r <= last_s;
          end
`else
          state_r <= ST_RUN;
`endif
        end
`ifdef BATCH_FLUSH_EN
        ST_DRAIN: begin
          if (last_s && drain_cnt_r) begin
            state_r     <= ST_IDLE;
            batch_idx_r <= 2'd0;
            drain_cnt_r <= 1'b0;
            idle_clr_r  <= 1'b1;
          end else if (last_s) begin
            drain_cnt_r <= 1'b1;
          end
        end
`endif
        default: state_r <= ST_IDLE;
      endcase
    end
`ifdef BATCH_FLUSH_EN
    // After a drain the final stream beat is retired once the block is idle.
    else if (idle_clr_r) begin
      stream_valid <= 1'b0;
      lh_clear     <= 1'b0;
      cb_load      <= 1'b0;
      idle_clr_r   <= 1'b0;
    end
`endif
  end

  assign out_valid = ov_pipe_r[LAT-1];

  for (genvar k = 0; k < M; k++) begin : g_ch
    batch_bank #(
      .DEPTH(DEPTH),
      .N    (N)
    ) u_bank (
      .clk     (clk),
      .rst     (rst),
      .beat    (beat_s),
      .wr_bank (batch_idx_r),
      .lh_bank (lh_bank_s),
      .co_bank (co_bank_s),
      .fwd_addr(bat_count),
      .rev_addr(bat_count_rev),
      .wr_data (wr_data_s[k*N +: N]),
      .s_lh    (s_lh[k*N +: N]),
      .s_cof   (s_cof[k*N +: N]),
      .s_cob   (s_cob[k*N +: N])
    );
  end

endmodule

// File: tb/tb_batch_sequencer.sv
// Self-checking bench for batch_sequencer: directed sequences plus random
// in_valid/data/reset, compared against a sample-history reference model.
module tb_batch_sequencer;

  localparam int D   = 4;
  localparam int N   = 8;
  localparam int M   = 2;
  localparam int LAT = 4;
  localparam int W   = M * N;
  localparam int AW  = $clog2(D);

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic [W-1:0]  in_data;
  logic [W-1:0]  s_lh, s_cof, s_cob;
  logic [AW-1:0] bat_count, bat_count_rev;
  logic          lh_clear, cb_load, wr_sel, stream_valid, out_valid;

  int n_pass  = 0;
  int n_total = 0;
  int nbeats  = 0;
  logic [W-1:0] hist[$];

  always #5 clk = ~clk;

  batch_sequencer #(.DEPTH(D), .N(N), .M(M), .LAT(LAT)) dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .s_lh         (s_lh),
    .s_cof        (s_cof),
    .s_cob        (s_cob),
    .bat_count    (bat_count),
    .bat_count_rev(bat_count_rev),
    .lh_clear     (lh_clear),
    .cb_load      (cb_load),
    .wr_sel       (wr_sel),
    .stream_valid (stream_valid),
    .out_valid    (out_valid)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  // Streams carry batch j-2 (and j-1 for lookahead) once two batches are banked.
  function automatic logic sv_after(input int b);
    return (b >= 0) && ((b / D) >= 2);
  endfunction

  task automatic check_all();
    int b, j, p, nc;
    if (nbeats == 0) begin
      check("rst_bat_count", 32'(bat_count), 32'd0);
      check("rst_bat_count_rev", 32'(bat_count_rev), 32'(D - 1));
      check("rst_wr_sel", 32'(wr_sel), 32'd0);
      check("rst_lh_clear", 32'(lh_clear), 32'd0);
      check("rst_cb_load", 32'(cb_load), 32'd0);
      check("rst_stream_valid", 32'(stream_valid), 32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_s_lh", 32'(s_lh), 32'd0);
      check("rst_s_cof", 32'(s_cof), 32'd0);
      check("rst_s_cob", 32'(s_cob), 32'd0);
    end else begin
      b  = nbeats - 1;
      j  = b / D;
      p  = b % D;
      nc = (b + 1) % D;
      check("bat_count", 32'(bat_count), 32'(nc));
      check("bat_count_rev", 32'(bat_count_rev), 32'(D - 1 - nc));
      check("wr_sel", 32'(wr_sel), 32'(((b + 1) / D) % 2));
      check("lh_clear", 32'(lh_clear), 32'(p == 0));
      check("cb_load", 32'(cb_load), 32'((p == 0) && (j >= 2)));
      check("stream_valid", 32'(stream_valid), 32'(sv_after(b)));
      check("out_valid", 32'(out_valid), 32'(sv_after(b - LAT)));
      if (j >= 2) begin
        check("s_cof", 32'(s_cof), 32'(hist[(j - 2) * D + p]));
        check("s_cob", 32'(s_cob), 32'(hist[(j - 2) * D + (D - 1 - p)]));
        check("s_lh", 32'(s_lh), 32'(hist[(j - 1) * D + (D - 1 - p)]));
      end
    end
  endtask

  task automatic step(input logic r, input logic v, input logic [W-1:0] d);
    rst      = r;
    in_valid = v;
    in_data  = d;
    @(posedge clk);
    #1;
    if (r) begin
      nbeats = 0;
      hist.delete();
    end else if (v) begin
      hist.push_back(d);
      nbeats++;
    end
    check_all();
  endtask

  function automatic logic [W-1:0] pat(input int i);
    return {8'(100 + i), 8'(i)};
  endfunction

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    in_data  = {W{1'b0}};

    // Reset with in_valid high: reset must win.
    step(1'b1, 1'b1, W'($urandom));
    step(1'b1, 1'b1, W'($urandom));

    // Continuous samples 1..13, ch1 offset by 100.
    for (int i = 1; i <= 13; i++) begin
      step(1'b0, 1'b1, pat(i));
      if (i == 8) check("sv_low_beat9", 32'(stream_valid), 32'd0);
      if (i == 9) begin
        check("cof0_first", 32'(s_cof[7:0]), 32'd1);
        check("cob0_first", 32'(s_cob[7:0]), 32'd4);
        check("lh0_first", 32'(s_lh[7:0]), 32'd8);
        check("cof1_first", 32'(s_cof[15:8]), 32'd101);
        check("lh1_first", 32'(s_lh[15:8]), 32'd108);
        check("sv_high_beat10", 32'(stream_valid), 32'd1);
      end
      if (i == 12) begin
        check("cof0_last", 32'(s_cof[7:0]), 32'd4);
        check("cob0_last", 32'(s_cob[7:0]), 32'd1);
        check("lh0_last", 32'(s_lh[7:0]), 32'd5);
        check("ov_low_lat3", 32'(out_valid), 32'd0);
      end
      if (i == 13) check("ov_high_lat4", 32'(out_valid), 32'd1);
    end

    // Reset at the sixth RUN beat, then two fresh batches before streaming.
    step(1'b1, 1'b1, pat(14));
    check("mid_rst_sv", 32'(stream_valid), 32'd0);
    check("mid_rst_cof", 32'(s_cof), 32'd0);
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b1, pat(20 + i));
    end

    // Same stimulus with idle cycles interleaved.
    step(1'b1, 1'b0, {W{1'b0}});
    for (int i = 1; i <= 13; i++) begin
      step(1'b0, 1'b0, W'($urandom));
      step(1'b0, 1'b1, pat(i));
      if (i == 9) check("gap_cof0_first", 32'(s_cof[7:0]), 32'd1);
    end

    // Random traffic with occasional reset.
    for (int c = 0; c < 800; c++) begin
      step(($urandom_range(0, 149) == 0), ($urandom_range(0, 2) != 0), W'($urandom));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/batch_sequencer.md
BATCH_SEQUENCER -- requirements
Module: batch_sequencer

Interface
REQ-001 SHALL have parameter DEPTH, default 32, meaning samples per batch (power of two, >= 4).
REQ-002 SHALL have parameter N, default 3, meaning bits per control sample.
REQ-003 SHALL have parameter M, default 1, meaning independent input channels sharing one sequencer.
REQ-004 SHALL have parameter LAT, default 4, meaning downstream compute latency in cycles matched by out_valid.
REQ-005 SHALL have ports: clk in 1, single clock; rst in 1, synchronous active-high reset.
REQ-006 SHALL have ports: in_valid in 1, sample beat qualifier; in_data in M*N, channel k in bits [k*N +: N].
REQ-007 SHALL have ports: s_lh out M*N, lookahead stream; s_cof out M*N, forward compute stream; s_cob out M*N, backward compute stream.
REQ-008 SHALL have ports: bat_count out clog2(DEPTH), forward index; bat_count_rev out clog2(DEPTH), DEPTH-1-bat_count.
REQ-009 SHALL have ports: lh_clear out 1, first beat of a batch; cb_load out 1, first beat of a batch in RUN; wr_sel out 1, part-result bank parity.
REQ-010 SHALL have ports: stream_valid out 1, streams meaningful; out_valid out 1, stream_valid delayed LAT beats.

Function
REQ-011 SHALL store samples in 3 banks per channel, each DEPTH x N, write bank w = batch_idx mod 3.
REQ-012 SHALL advance bat_count, write, read and shift out_valid only on beats with in_valid=1; all outputs hold when in_valid=0.
REQ-013 SHALL write in_data to bank w at address bat_count on each beat.
REQ-014 SHALL read s_lh from bank (w-1) mod 3 at bat_count_rev, s_cof and s_cob from bank (w-2) mod 3 at bat_count and bat_count_rev respectively.
REQ-015 SHALL register all three streams, valid one beat after the addressing beat.
REQ-016 SHALL wrap bat_count DEPTH-1 -> 0, incrementing batch_idx mod 3 and toggling wr_sel on the same beat.
REQ-017 SHALL implement states IDLE, FILL, RUN: IDLE -> FILL on first in_valid beat; FILL -> RUN on completing the second batch; RUN persists until reset (or flush, REQ-024).
REQ-018 SHALL assert stream_valid only for stream data produced in RUN.
REQ-019 SHALL assert lh_clear and cb_load aligned with the registered stream beat carrying bat_count=0 data.
REQ-020 SHALL produce out_valid through a LAT-stage shift register of stream_valid, advancing on in_valid beats.

Reset
REQ-021 SHALL on rst=1 set state IDLE, bat_count=0, bat_count_rev=DEPTH-1, batch_idx=0, wr_sel=0, all streams 0, all flags 0, out_valid pipeline cleared.
REQ-022 SHALL on reset mid-batch discard all banked samples logically (FILL restarts); bank contents need not be cleared.
REQ-023 SHALL give rst priority over in_valid in the same cycle.

Configuration
REQ-024 SHALL, with BATCH_FLUSH_EN defined, add input flush (1 bit): in RUN, flush=1 makes the block self-clock zero samples without in_valid until two further batch boundaries pass, then go IDLE; in_valid ignored during flush.
REQ-025 SHALL, without BATCH_FLUSH_EN, omit the flush port and drain logic; a pending tail is only emitted by further input.

Structure
REQ-026 SHALL place state enum, bank-index helper (mod-3 subtract) and default parameter constants in the shared util package.
REQ-027 SHALL instantiate one sub-module per channel, batch_bank (3-bank dual-read sample store), generated M times.

Verification
REQ-028 Reset then DEPTH=4, M=1, continuous in_valid, samples 1..12 -> stream_valid first high on beat 10; s_cof 1,2,3,4 and s_cob 4,3,2,1 on beats 10-13; s_lh 8,7,6,5.
REQ-029 Same stimulus with in_valid low every other cycle -> identical stream sequence, bat_count holds on idle cycles.
REQ-030 M=2, ch0 = i, ch1 = 100+i -> channels separated in streams; no cross-talk.
REQ-031 Reset asserted at beat 6 of RUN -> all outputs 0 next cycle, stream_valid returns only after two fresh batches.
REQ-032 LAT=4 -> out_valid rises exactly 4 beats after stream_valid; lh_clear/cb_load pulse once per batch at bat_count=0 data.
REQ-033 BATCH_FLUSH_EN, flush at batch boundary after samples 1..12 -> last batch 9..12 emitted forward and reversed, then IDLE, stream_valid low.
